// File: rtl/loop_bank_scheduler_if.sv
// Sample-pulse, bank-mask and RAM-strobe bundle for loop_bank_scheduler.
// The master side is the scheduler; the slave side is the RAM controller / sample path.
interface loop_bank_scheduler_if #(
  parameter int NUM_BANKS = 16,
  parameter int BANK_W    = $clog2(NUM_BANKS),
  parameter int BLOCK_W   = 22
);
  logic                 pulse;
  logic [NUM_BANKS-1:0] playing;
  logic [NUM_BANKS-1:0] recording;
  logic [NUM_BANKS-1:0] clear;
  logic [BLOCK_W-1:0]   max_block;
  logic                 read_valid;
  logic                 ram_cen;
  logic                 ram_oen;
  logic                 ram_wen;
  logic                 write_zero;
  logic                 get_data;
  logic                 data_ready;
  logic [BANK_W-1:0]    data_bank;
  logic                 rd_err;
  logic [BLOCK_W-1:0]   block_addr;
  logic [BANK_W-1:0]    bank;
  logic                 busy;
  logic                 overrun;

  modport master (
    input  pulse, playing, recording, clear, max_block, read_valid,
    output ram_cen, ram_oen, ram_wen, write_zero, get_data, data_ready,
           data_bank, rd_err, block_addr, bank, busy, overrun
  );

  modport slave (
    output pulse, playing, recording, clear, max_block, read_valid,
    input  ram_cen, ram_oen, ram_wen, write_zero, get_data, data_ready,
           data_bank, rd_err, block_addr, bank, busy, overrun
  );
endinterface

// File: rtl/loop_bank_scheduler.sv
// Per-sample loop bank scheduler: walks every bank once per sample pulse issuing clear/record/play/skip.
// Define LOOP_READ_TIMEOUT_EN to abort reads after READ_TIMEOUT cycles and report rd_err.
module loop_bank_scheduler #(
  parameter int NUM_BANKS    = 16,
  parameter int BANK_W       = $clog2(NUM_BANKS),
  parameter int BLOCK_W      = 22,
  parameter int WRITE_CYCLES = 62,
  parameter int READ_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  loop_bank_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, DISPATCH, WRITE, READ, FLAG, ADVANCE
  } state_e;

  // One counter serves both the write hold and the read timeout, so size it for the larger.
  localparam int CNT_MAX = (WRITE_CYCLES > READ_TIMEOUT) ? WRITE_CYCLES : READ_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e               state_q, state_d;
  logic [BANK_W-1:0]    bank_q, bank_d;
  logic [BLOCK_W-1:0]   block_q, block_d;
  logic [NUM_BANKS-1:0] play_q, play_d, rec_q, rec_d, clr_q, clr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cen_q, cen_d, oen_q, oen_d, wen_q, wen_d;
  logic                 wz_q, wz_d, get_q, get_d, dr_q, dr_d;
  logic [BANK_W-1:0]    dbank_q, dbank_d;
  logic                 busy_q, busy_d, ovr_q, ovr_d;
`ifdef LOOP_READ_TIMEOUT_EN
  logic                 rderr_q, rderr_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bank_q  <= '0;
      block_q <= '0;
      play_q  <= '0;
      rec_q   <= '0;
      clr_q   <= '0;
      cnt_q   <= '0;
      cen_q   <= 1'b1;
      oen_q   <= 1'b1;
      wen_q   <= 1'b1;
      wz_q    <= 1'b0;
      get_q   <= 1'b0;
      dr_q    <= 1'b0;
      dbank_q <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef LOOP_READ_TIMEOUT_EN
      rderr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      block_q <= block_d;
      play_q  <= play_d;
      rec_q   <= rec_d;
      clr_q   <= clr_d;
      cnt_q   <= cnt_d;
      cen_q   <= cen_d;
      oen_q   <= oen_d;
      wen_q   <= wen_d;
      wz_q    <= wz_d;
      get_q   <= get_d;
      dr_q    <= dr_d;
      dbank_q <= dbank_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
`ifdef LOOP_READ_TIMEOUT_EN
      rderr_q <= rderr_d;
`endif
    end
  end

  // Every output is computed from the next state so the registered value lines up with it.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    block_d = block_q;
    play_d  = play_q;
    rec_d   = rec_q;
    clr_d   = clr_q;
    cnt_d   = cnt_q;
    cen_d   = 1'b1;
    oen_d   = 1'b1;
    wen_d   = 1'b1;
    wz_d    = 1'b0;
    get_d   = 1'b0;
    dr_d    = 1'b0;
    dbank_d = dbank_q;
    ovr_d   = bus.pulse && (state_q != IDLE);
`ifdef LOOP_READ_TIMEOUT_EN
    rderr_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.pulse) begin
          play_d  = bus.playing;
          rec_d   = bus.recording;
          clr_d   = bus.clear;
          bank_d  = '0;
          state_d = DISPATCH;
        end
      end

      DISPATCH: begin
        cnt_d = '0;
        if (clr_q[bank_q]) begin
          wz_d    = 1'b1;
          cen_d   = 1'b0;
          wen_d   = 1'b0;
          state_d = WRITE;
        end else if (rec_q[bank_q]) begin
          get_d   = 1'b1;
          cen_d   = 1'b0;
          wen_d   = 1'b0;
          state_d = WRITE;
        end else if (play_q[bank_q]) begin
          cen_d   = 1'b0;
          oen_d   = 1'b0;
          state_d = READ;
        end else begin
          dr_d    = 1'b1;
          dbank_d = bank_q;
          state_d = FLAG;
        end
      end

      WRITE: begin
        if (cnt_q == CNT_W'(WRITE_CYCLES - 1)) begin
          dr_d    = 1'b1;
          dbank_d = bank_q;
          state_d = FLAG;
        end else begin
          cnt_d = cnt_q + 1'b1;
          cen_d = 1'b0;
          wen_d = 1'b0;
          wz_d  = wz_q;
        end
      end

      READ: begin
        if (bus.read_valid) begin
          dr_d    = 1'b1;
          dbank_d = bank_q;
          state_d = FLAG;
        end
`ifdef LOOP_READ_TIMEOUT_EN
        else if (cnt_q == CNT_W'(READ_TIMEOUT - 1)) begin
          dr_d    = 1'b1;
          dbank_d = bank_q;
          rderr_d = 1'b1;
          state_d = FLAG;
        end
`endif
        else begin
`ifdef LOOP_READ_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
          cen_d = 1'b0;
          oen_d = 1'b0;
        end
      end

      FLAG: begin
        if (bank_q == BANK_W'(NUM_BANKS - 1)) begin
          state_d = ADVANCE;
        end else begin
          bank_d  = bank_q + 1'b1;
          state_d = DISPATCH;
        end
      end

      ADVANCE: begin
        bank_d  = '0;
        state_d = IDLE;
        // An idle looper parks at block 0; the >= also catches a loop shortened under the pointer.
        if ((play_q | rec_q | clr_q) == '0) begin
          block_d = '0;
        end else if ((bus.max_block != '0) && (block_q >= bus.max_block - 1'b1)) begin
          block_d = '0;
        end else begin
          block_d = block_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.ram_cen    = cen_q;
  assign bus.ram_oen    = oen_q;
  assign bus.ram_wen    = wen_q;
  assign bus.write_zero = wz_q;
  assign bus.get_data   = get_q;
  assign bus.data_ready = dr_q;
  assign bus.data_bank  = dbank_q;
  assign bus.block_addr = block_q;
  assign bus.bank       = bank_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = ovr_q;
`ifdef LOOP_READ_TIMEOUT_EN
  assign bus.rd_err     = rderr_q;
`else
  assign bus.rd_err     = 1'b0;
`endif

endmodule

// File: tb/tb_loop_bank_scheduler.sv
// Directed bench for loop_bank_scheduler with NUM_BANKS=4, WRITE_CYCLES=8, max_block=3.
// A negedge monitor accumulates strobe/handshake counts that each step compares against hand-derived values.
module tb_loop_bank_scheduler;

  localparam int NB   = 4;
  localparam int BW   = $clog2(NB);
  localparam int BLKW = 22;
  localparam int WC   = 8;
  localparam int RT   = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  loop_bank_scheduler_if #(.NUM_BANKS(NB), .BANK_W(BW), .BLOCK_W(BLKW)) bus ();

  loop_bank_scheduler #(
    .NUM_BANKS(NB), .BANK_W(BW), .BLOCK_W(BLKW),
    .WRITE_CYCLES(WC), .READ_TIMEOUT(RT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  int cycleCount = 0, busyCycles = 0, drCount = 0, cenLow = 0, oenLow = 0, wenLow = 0;
  int getCount = 0, wzCount = 0, ovCount = 0, rdErrCount = 0, clashCount = 0;
  int drBanks[$];
  int drCycles[$];

  int sBusy, sDr, sCen, sOen, sWen, sGet, sWz, sOv, sRdErr, sQ;

  // Counts per-cycle activity mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    cycleCount++;
    if (rst === 1'b0) begin
      if (bus.busy === 1'b1) busyCycles++;
      if (bus.ram_cen === 1'b0) cenLow++;
      if (bus.ram_oen === 1'b0) oenLow++;
      if (bus.ram_wen === 1'b0) wenLow++;
      if (bus.get_data === 1'b1) getCount++;
      if (bus.write_zero === 1'b1) wzCount++;
      if (bus.overrun === 1'b1) ovCount++;
      if (bus.rd_err === 1'b1) rdErrCount++;
      if (bus.data_ready === 1'b1) begin
        drCount++;
        drBanks.push_back(int'(bus.data_bank));
        drCycles.push_back(cycleCount);
        if (bus.ram_cen !== 1'b1 || bus.ram_oen !== 1'b1 || bus.ram_wen !== 1'b1) clashCount++;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NB-1:0] p, input logic [NB-1:0] r,
                               input logic [NB-1:0] c, input logic [BLKW-1:0] mb);
    bus.playing   = p;
    bus.recording = r;
    bus.clear     = c;
    bus.max_block = mb;
  endtask

  task automatic takeSnapshot();
    sBusy = busyCycles; sDr = drCount; sCen = cenLow; sOen = oenLow; sWen = wenLow;
    sGet = getCount; sWz = wzCount; sOv = ovCount; sRdErr = rdErrCount; sQ = drBanks.size();
  endtask

  task automatic firePulse();
    bus.pulse = 1'b1;
    tick();
    bus.pulse = 1'b0;
  endtask

  task automatic waitIdle(input int limit, input string tag);
    int n = 0;
    while (bus.busy === 1'b1 && n < limit) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(bus.busy), 32'd0);
  endtask

  // sel 0 waits for ram_oen low, sel 1 for ram_wen low.
  task automatic waitLow(input int sel, input int limit, input string tag);
    int n = 0;
    while (((sel == 0) ? bus.ram_oen : bus.ram_wen) !== 1'b0 && n < limit) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'((sel == 0) ? bus.ram_oen : bus.ram_wen), 32'd0);
  endtask

  initial begin
    int expBlk[3];
    int n;
    expBlk = '{1, 2, 0};

    rst = 1'b1;
    bus.pulse = 1'b0;
    bus.read_valid = 1'b0;
    applyStimulus('0, '0, '0, BLKW'(3));
    #1;
    checkOutput("rst cen", 32'(bus.ram_cen), 32'd1);
    checkOutput("rst oen", 32'(bus.ram_oen), 32'd1);
    checkOutput("rst wen", 32'(bus.ram_wen), 32'd1);
    checkOutput("rst busy", 32'(bus.busy), 32'd0);
    repeat (3) tick();
    checkOutput("rst write_zero", 32'(bus.write_zero), 32'd0);
    checkOutput("rst get_data", 32'(bus.get_data), 32'd0);
    checkOutput("rst data_ready", 32'(bus.data_ready), 32'd0);
    checkOutput("rst data_bank", 32'(bus.data_bank), 32'd0);
    checkOutput("rst rd_err", 32'(bus.rd_err), 32'd0);
    checkOutput("rst block_addr", 32'(bus.block_addr), 32'd0);
    checkOutput("rst bank", 32'(bus.bank), 32'd0);
    checkOutput("rst overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] all masks zero, single pulse");
    takeSnapshot();
    firePulse();
    checkOutput("t1 busy rises", 32'(bus.busy), 32'd1);
    waitIdle(100, "t1 idle");
    checkOutput("t1 busy cycles", 32'(busyCycles - sBusy), 32'd9);
    checkOutput("t1 data_ready count", 32'(drCount - sDr), 32'd4);
    checkOutput("t1 cen low cycles", 32'(cenLow - sCen), 32'd0);
    checkOutput("t1 block_addr", 32'(bus.block_addr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t1 data_bank[%0d]", i), 32'(drBanks[sQ + i]), 32'(i));
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t1 spacing[%0d]", i), 32'(drCycles[sQ + i + 1] - drCycles[sQ + i]), 32'd2);
    end

    $display("[TB] bank 1 recording, three pulses");
    applyStimulus('0, 4'b0010, '0, BLKW'(3));
    for (int p = 0; p < 3; p++) begin
      takeSnapshot();
      firePulse();
      waitIdle(200, $sformatf("t2 idle[%0d]", p));
      checkOutput($sformatf("t2 busy cycles[%0d]", p), 32'(busyCycles - sBusy), 32'd17);
      checkOutput($sformatf("t2 get_data[%0d]", p), 32'(getCount - sGet), 32'd1);
      checkOutput($sformatf("t2 wen low[%0d]", p), 32'(wenLow - sWen), 32'd8);
      checkOutput($sformatf("t2 write_zero[%0d]", p), 32'(wzCount - sWz), 32'd0);
      checkOutput($sformatf("t2 block_addr[%0d]", p), 32'(bus.block_addr), 32'(expBlk[p]));
    end

    $display("[TB] bank 0 clear and record together");
    applyStimulus('0, 4'b0001, 4'b0001, BLKW'(3));
    takeSnapshot();
    firePulse();
    waitIdle(200, "t3 idle");
    checkOutput("t3 write_zero cycles", 32'(wzCount - sWz), 32'd8);
    checkOutput("t3 get_data", 32'(getCount - sGet), 32'd0);
    checkOutput("t3 wen low", 32'(wenLow - sWen), 32'd8);
    checkOutput("t3 block_addr", 32'(bus.block_addr), 32'd1);

    $display("[TB] bank 2 play with overlapping pulse");
    applyStimulus(4'b0100, '0, '0, BLKW'(3));
    takeSnapshot();
    firePulse();
    waitLow(0, 50, "t4 oen asserted");
    bus.pulse = 1'b1;
    tick();
    checkOutput("t4 overrun high", 32'(bus.overrun), 32'd1);
    bus.pulse = 1'b0;
    tick();
    checkOutput("t4 overrun low", 32'(bus.overrun), 32'd0);
    tick();
    tick();
    bus.read_valid = 1'b1;
    tick();
    bus.read_valid = 1'b0;
    checkOutput("t4 data_ready", 32'(bus.data_ready), 32'd1);
    checkOutput("t4 data_bank", 32'(bus.data_bank), 32'd2);
    checkOutput("t4 rd_err", 32'(bus.rd_err), 32'd0);
    checkOutput("t4 oen released", 32'(bus.ram_oen), 32'd1);
    waitIdle(100, "t4 idle");
    repeat (5) tick();
    checkOutput("t4 oen low cycles", 32'(oenLow - sOen), 32'd5);
    checkOutput("t4 overrun count", 32'(ovCount - sOv), 32'd1);
    checkOutput("t4 data_ready count", 32'(drCount - sDr), 32'd4);
    checkOutput("t4 busy cycles", 32'(busyCycles - sBusy), 32'd14);
    checkOutput("t4 block_addr", 32'(bus.block_addr), 32'd2);

    takeSnapshot();
    bus.read_valid = 1'b1;
    tick();
    bus.read_valid = 1'b0;
    tick();
    checkOutput("stray read_valid busy", 32'(busyCycles - sBusy), 32'd0);
    checkOutput("stray read_valid data_ready", 32'(drCount - sDr), 32'd0);

    $display("[TB] loop shortened under the pointer");
    applyStimulus('0, '0, 4'b1000, BLKW'(2));
    takeSnapshot();
    firePulse();
    waitIdle(200, "t5 idle");
    checkOutput("t5 busy cycles", 32'(busyCycles - sBusy), 32'd17);
    checkOutput("t5 block_addr", 32'(bus.block_addr), 32'd0);

`ifdef LOOP_READ_TIMEOUT_EN
    $display("[TB] read timeout");
    applyStimulus(4'b0100, '0, '0, BLKW'(3));
    takeSnapshot();
    firePulse();
    waitLow(0, 50, "t6 oen asserted");
    n = 0;
    while (bus.data_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("t6 data_ready", 32'(bus.data_ready), 32'd1);
    checkOutput("t6 rd_err", 32'(bus.rd_err), 32'd1);
    checkOutput("t6 data_bank", 32'(bus.data_bank), 32'd2);
    bus.read_valid = 1'b1;
    tick();
    bus.read_valid = 1'b0;
    waitIdle(100, "t6 idle");
    checkOutput("t6 oen low cycles", 32'(oenLow - sOen), 32'd16);
    checkOutput("t6 rd_err count", 32'(rdErrCount - sRdErr), 32'd1);
    checkOutput("t6 data_ready count", 32'(drCount - sDr), 32'd4);
`endif

    $display("[TB] reset during write");
    applyStimulus('0, 4'b0001, '0, BLKW'(3));
    firePulse();
    waitLow(1, 50, "t7 wen asserted");
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("t7 wen after reset", 32'(bus.ram_wen), 32'd1);
    checkOutput("t7 cen after reset", 32'(bus.ram_cen), 32'd1);
    checkOutput("t7 busy after reset", 32'(bus.busy), 32'd0);
    checkOutput("t7 block_addr after reset", 32'(bus.block_addr), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("t7 stays idle", 32'(bus.busy), 32'd0);

    checkOutput("data_ready strobe clash", 32'(clashCount), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
